// File: rtl/ifetch_pc_unit.sv
// rtl/ifetch_pc_unit.sv - instruction-fetch program counter, IF/ID register and run/step/halt control
module ifetch_pc_unit #(
  parameter int          ADDR_W   = 10,
  parameter int          DATA_W   = 32,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              step,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  input  logic              halt_req,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] ir,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              ir_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              pc_wrapped,
  output logic [31:0]       fetch_count
);

  logic step_q;
  logic step_rise;
  logic adv;

  // A held step only counts once: advance on its rising edge, or every cycle when running.
  always_comb begin
    step_rise = step & ~step_q;
    adv       = ~halted & (run | step_rise);
    rom_addr  = pc;
  end

  // Step edge detector history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q <= 1'b0;
    end else begin
      step_q <= step;
    end
  end

  // Fetch state: halt beats everything, then advance gating, redirect, stall, sequential fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= ADDR_W'(RESET_PC);
      ir          <= '0;
      ir_pc       <= '0;
      ir_valid    <= 1'b0;
      halted      <= 1'b0;
      pc_wrapped  <= 1'b0;
      fetch_count <= '0;
    end else if (halt_req) begin
      halted   <= 1'b1;
      ir       <= '0;
      ir_valid <= 1'b0;
    end else if (!adv) begin
      // frozen: paused in step mode, or halted
    end else if (redirect_valid) begin
      // the word fetched this cycle is on the wrong path, so it becomes a bubble
      pc       <= redirect_target;
      ir       <= '0;
      ir_valid <= 1'b0;
    end else if (stall) begin
      // decode is holding; keep PC and IR as they are
    end else begin
      ir       <= rom_data;
      ir_pc    <= pc;
      ir_valid <= 1'b1;
      pc       <= pc + ADDR_W'(1);
      if (&pc) begin
        pc_wrapped <= 1'b1;
      end
      if (fetch_count != 32'hFFFF_FFFF) begin
        fetch_count <= fetch_count + 32'd1;
      end
    end
  end

endmodule
